// File: rtl/keys_pio_if.sv
// Zero-wait-state Avalon-MM slave bus bundle shared by the PIO peripherals.
interface keys_pio_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata
  );
endinterface

// File: rtl/keys_pio.sv
// Input PIO: synchronizes and debounces a button/switch bus, captures rising
// edges in a W1C register and raises a maskable level interrupt.
module keys_pio #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic             clk,
  input  logic             reset_n,
  keys_pio_if.slave        bus,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  localparam int            CW   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [CW-1:0]    count;
  logic             tick;
  logic [WIDTH-1:0] sync1, sync2, snap, db, db_d;
  logic [WIDTH-1:0] rise, edge_cap, mask;
  logic [WIDTH-1:0] wdata_lo;
  logic             wr, wr_mask, wr_clr;

  assign tick     = (count == LAST);
  assign rise     = db & ~db_d;
  assign wdata_lo = bus.writedata[WIDTH-1:0];
  assign wr       = bus.chipselect && !bus.write_n;
  assign wr_mask  = wr && (bus.address == 2'd2);
  assign wr_clr   = wr && (bus.address == 2'd3);
  assign irq      = |(edge_cap & mask);

  generate
    if (WIDTH < 32) begin : g_wdata_hi
      logic unused_wdata_hi;
      assign unused_wdata_hi = ^bus.writedata[31:WIDTH];
    end
  endgenerate

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      count <= tick ? '0 : count + CW'(1);
      sync1 <= in_port;
      sync2 <= sync1;
    end
  end

  // A bit reaches db only once two consecutive tick samples agree.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      snap <= '0;
      db   <= '0;
      db_d <= '0;
    end else begin
      if (tick) begin
        snap <= sync2;
        for (int i = 0; i < WIDTH; i++) begin
          if (sync2[i] == snap[i]) db[i] <= sync2[i];
        end
      end
      db_d <= db;
    end
  end

  // A rise in the same cycle as a W1C clear keeps the bit set.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      edge_cap <= '0;
      mask     <= '0;
    end else begin
      edge_cap <= rise | (edge_cap & ~(wr_clr ? wdata_lo : '0));
      if (wr_mask) mask <= wdata_lo;
    end
  end

  always_comb begin
    bus.readdata = '0;
    if (bus.chipselect) begin
      case (bus.address)
        2'd0:    bus.readdata[WIDTH-1:0] = db;
        2'd2:    bus.readdata[WIDTH-1:0] = mask;
        2'd3:    bus.readdata[WIDTH-1:0] = edge_cap;
        default: bus.readdata = '0;
      endcase
    end
  end

endmodule
